// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares two SRAM read ports and one write port among four
// read requesters and a single writer. Reads are granted round-robin, up to two
// per cycle; a write beats a read to the same address, with a small starvation
// counter that lets blocked reads through after three consecutive collisions.
// All decoder-side outputs are registered (1-cycle handshake-to-enable latency).
module sram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rd_valid,
    input  logic [27:0] rd_addr,
    output logic [3:0]  rd_ready,
    input  logic        wr_valid,
    input  logic [6:0]  wr_addr,
    output logic        wr_ready,
    output logic [6:0]  address_1,
    output logic [6:0]  address_2,
    output logic [1:0]  read_enable,
    output logic [6:0]  address_w,
    output logic        write_enable,
    output logic [1:0]  port_id_1,
    output logic [1:0]  port_id_2
);

    // Arbitration state
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] block_cnt_q, block_cnt_d;

    // Registered decoder-side outputs
    logic [6:0] address_1_q, address_1_d;
    logic [6:0] address_2_q, address_2_d;
    logic [1:0] read_enable_q, read_enable_d;
    logic [6:0] address_w_q, address_w_d;
    logic       write_enable_q, write_enable_d;
    logic [1:0] port_id_1_q, port_id_1_d;
    logic [1:0] port_id_2_q, port_id_2_d;

    // Combinational arbitration results
    logic [6:0] req_addr [4];
    logic [3:0] collide;
    logic [3:0] eligible;
    logic       starve;
    logic [1:0] scan_idx;
    logic [1:0] n_grant;
    logic [1:0] grant_1;
    logic [1:0] grant_2;

    // Unpack the requester addresses, then decide the write grant and which
    // reads are eligible (a write to the same address wins unless starving).
    always_comb begin
        starve   = (block_cnt_q == 2'd3);
        wr_ready = wr_valid && !starve && !rst;
        collide  = '0;
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = rd_addr[7*i +: 7];
            collide[i]  = rd_valid[i] && wr_ready && (req_addr[i] == wr_addr);
            eligible[i] = rd_valid[i] && !collide[i] && !rst;
        end
    end

    // Round-robin scan from rr_ptr: the first eligible requester takes port 1,
    // the second takes port 2; later ones wait.
    // NOTE: every signal written here gets a default first, so no path through
    // the loop leaves one unassigned and no latch is inferred.
    always_comb begin
        n_grant  = 2'd0;
        grant_1  = 2'd0;
        grant_2  = 2'd0;
        scan_idx = 2'd0;
        rd_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (eligible[scan_idx]) begin
                if (n_grant == 2'd0) begin
                    grant_1            = scan_idx;
                    rd_ready[scan_idx] = 1'b1;
                    n_grant            = 2'd1;
                end else if (n_grant == 2'd1) begin
                    grant_2            = scan_idx;
                    rd_ready[scan_idx] = 1'b1;
                    n_grant            = 2'd2;
                end
            end
        end
    end

    // Next-state values for the pointer, starvation counter and port outputs.
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        block_cnt_d    = block_cnt_q;
        address_1_d    = address_1_q;
        address_2_d    = address_2_q;
        port_id_1_d    = port_id_1_q;
        port_id_2_d    = port_id_2_q;
        read_enable_d  = 2'b00;
        write_enable_d = wr_valid && wr_ready;
        address_w_d    = address_w_q;

        if (write_enable_d) begin
            address_w_d = wr_addr;
        end

        if (n_grant != 2'd0) begin
            read_enable_d[0] = 1'b1;
            address_1_d      = req_addr[grant_1];
            port_id_1_d      = grant_1;
            rr_ptr_d         = grant_1 + 2'd1;
        end
        if (n_grant == 2'd2) begin
            read_enable_d[1] = 1'b1;
            address_2_d      = req_addr[grant_2];
            port_id_2_d      = grant_2;
            rr_ptr_d         = grant_2 + 2'd1;
        end

        // Count consecutive write-collision cycles; clear on a quiet cycle or
        // once the starve cycle has let the blocked reads through.
        if (starve || (collide == 4'b0000)) begin
            block_cnt_d = 2'd0;
        end else begin
            block_cnt_d = block_cnt_q + 2'd1;
        end
    end

    // State and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= 2'd0;
            block_cnt_q    <= 2'd0;
            address_1_q    <= 7'd0;
            address_2_q    <= 7'd0;
            read_enable_q  <= 2'b00;
            address_w_q    <= 7'd0;
            write_enable_q <= 1'b0;
            port_id_1_q    <= 2'd0;
            port_id_2_q    <= 2'd0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            block_cnt_q    <= block_cnt_d;
            address_1_q    <= address_1_d;
            address_2_q    <= address_2_d;
            read_enable_q  <= read_enable_d;
            address_w_q    <= address_w_d;
            write_enable_q <= write_enable_d;
            port_id_1_q    <= port_id_1_d;
            port_id_2_q    <= port_id_2_d;
        end
    end

    assign address_1    = address_1_q;
    assign address_2    = address_2_q;
    assign read_enable  = read_enable_q;
    assign address_w    = address_w_q;
    assign write_enable = write_enable_q;
    assign port_id_1    = port_id_1_q;
    assign port_id_2    = port_id_2_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_valid;
    logic [27:0] rd_addr;
    logic [3:0]  rd_ready;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic        wr_ready;
    logic [6:0]  address_1, address_2, address_w;
    logic [1:0]  read_enable, port_id_1, port_id_2;
    logic        write_enable;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_ptr = 0;
    int         m_blk = 0;
    logic [6:0] m_a1 = '0, m_a2 = '0, m_aw = '0;
    logic [1:0] m_re = '0, m_p1 = '0, m_p2 = '0;
    logic       m_we = 1'b0;
    logic [3:0] e_rd;
    logic       e_wr;
    logic       e_blocked;
    int         grants[$];

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ready(wr_ready),
        .address_1(address_1), .address_2(address_2), .read_enable(read_enable),
        .address_w(address_w), .write_enable(write_enable),
        .port_id_1(port_id_1), .port_id_2(port_id_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] addr_of(input logic [27:0] bus, input int i);
        return bus[7*i +: 7];
    endfunction

    // Grants this cycle: walk requesters in round-robin order starting at the
    // pointer, skip blocked ones, keep the first two.
    task automatic model_comb();
        e_wr      = !rst && wr_valid && (m_blk != 3);
        e_rd      = '0;
        e_blocked = 1'b0;
        grants.delete();
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (rd_valid[i]) begin
                if (e_wr && addr_of(rd_addr, i) == wr_addr) e_blocked = 1'b1;
                else if (!rst && grants.size() < 2) grants.push_back(i);
            end
        end
        foreach (grants[j]) e_rd[grants[j]] = 1'b1;
    endtask

    task automatic model_clock();
        if (rst) begin
            m_ptr = 0; m_blk = 0; m_a1 = '0; m_a2 = '0; m_aw = '0;
            m_re = '0; m_p1 = '0; m_p2 = '0; m_we = 1'b0;
        end else begin
            m_we = e_wr;
            if (e_wr) m_aw = wr_addr;
            m_re = (grants.size() == 0) ? 2'b00 : (grants.size() == 1) ? 2'b01 : 2'b11;
            if (grants.size() >= 1) begin
                m_a1 = addr_of(rd_addr, grants[0]);
                m_p1 = 2'(grants[0]);
            end
            if (grants.size() == 2) begin
                m_a2 = addr_of(rd_addr, grants[1]);
                m_p2 = 2'(grants[1]);
            end
            if (grants.size() > 0) m_ptr = (grants[grants.size()-1] + 1) % 4;
            m_blk = (m_blk == 3 || !e_blocked) ? 0 : m_blk + 1;
        end
    endtask

    task automatic check_regs();
        check("read_enable", 32'(read_enable), 32'(m_re));
        check("address_1", 32'(address_1), 32'(m_a1));
        check("address_2", 32'(address_2), 32'(m_a2));
        check("port_id_1", 32'(port_id_1), 32'(m_p1));
        check("port_id_2", 32'(port_id_2), 32'(m_p2));
        check("write_enable", 32'(write_enable), 32'(m_we));
        check("address_w", 32'(address_w), 32'(m_aw));
    endtask

    // One clock: check registered outputs, apply inputs, check the
    // combinational grants, then advance the model at the rising edge.
    task automatic step(input logic r, input logic [3:0] v, input logic [27:0] a,
                        input logic w, input logic [6:0] wa);
        @(negedge clk);
        check_regs();
        rst = r; rd_valid = v; rd_addr = a; wr_valid = w; wr_addr = wa;
        #1;
        model_comb();
        check("rd_ready", 32'(rd_ready), 32'(e_rd));
        check("wr_ready", 32'(wr_ready), 32'(e_wr));
        @(posedge clk);
        model_clock();
    endtask

    logic [27:0] rnd_addr;

    initial begin
        rst = 1'b1; rd_valid = '0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
        step(1, 4'h0, 28'h0, 0, 7'h0);
        step(1, 4'hF, 28'hFFFFFFF, 1, 7'h7F);

        // Four requesters, no write: two grants, then the other two.
        step(0, 4'hF, {7'd8, 7'd7, 7'd6, 7'd5}, 0, 7'd0);
        #1;
        check("d036_re", 32'(read_enable), 32'd3);
        check("d036_a1", 32'(address_1), 32'd5);
        check("d036_a2", 32'(address_2), 32'd6);
        check("d036_p1p2", 32'({port_id_1, port_id_2}), 32'h1);
        step(0, 4'hF, {7'd8, 7'd7, 7'd6, 7'd5}, 0, 7'd0);
        #1;
        check("d036_p1_next", 32'(port_id_1), 32'd2);

        // Write beats a same-address read.
        step(0, 4'b0100, {7'd0, 7'd9, 7'd0, 7'd0}, 1, 7'd9);
        #1;
        check("d037_we", 32'(write_enable), 32'd1);
        check("d037_aw", 32'(address_w), 32'd9);
        check("d037_re", 32'(read_enable), 32'd0);
        step(0, 4'b0000, 28'h0, 0, 7'd0);

        // Persistent collision: three write cycles, then the read gets through.
        for (int c = 0; c < 3; c++) step(0, 4'b0001, 28'd3, 1, 7'd3);
        step(0, 4'b0001, 28'd3, 1, 7'd3);
        #1;
        check("d038_re", 32'(read_enable), 32'd1);
        check("d038_we", 32'(write_enable), 32'd0);
        step(0, 4'b0001, 28'd3, 1, 7'd3);
        step(0, 4'b0000, 28'h0, 0, 7'd0);

        // Single request on requester 2 moves the pointer to 3.
        step(0, 4'b0100, {7'd0, 7'h40, 7'd0, 7'd0}, 0, 7'd0);
        #1;
        check("d041_re", 32'(read_enable), 32'd1);
        check("d041_a1", 32'(address_1), 32'h40);
        check("d041_p1", 32'(port_id_1), 32'd2);

        // Same-address reads from requesters 3 and 0 with pointer at 3.
        step(0, 4'b1001, {7'h7F, 7'd0, 7'd0, 7'h7F}, 0, 7'd0);
        #1;
        check("d039_re", 32'(read_enable), 32'd3);
        check("d039_addr", 32'({address_1, address_2}), 32'h3FFF);
        check("d039_ids", 32'({port_id_1, port_id_2}), 32'hC);

        // Reset pulse in the middle of traffic.
        step(0, 4'hF, {7'd4, 7'd3, 7'd2, 7'd1}, 1, 7'd2);
        step(0, 4'hF, {7'd4, 7'd3, 7'd2, 7'd1}, 1, 7'd2);
        step(1, 4'hF, {7'd4, 7'd3, 7'd2, 7'd1}, 1, 7'd2);
        #1;
        check("d040_zero", 32'({read_enable, write_enable, address_1, address_2, address_w,
                                port_id_1, port_id_2}), 32'd0);
        step(0, 4'hF, {7'd4, 7'd3, 7'd2, 7'd1}, 0, 7'd0);
        #1;
        check("d040_p1", 32'(port_id_1), 32'd0);

        // Randomized traffic with a narrow address range to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                rnd_addr[7*i +: 7] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 3));
            step(($urandom_range(0, 49) == 0), 4'($urandom), rnd_addr,
                 ($urandom_range(0, 3) != 0), 7'($urandom_range(0, 3)));
        end
        @(negedge clk);
        check_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
